mips_trace_buffer: RTL and testbench
====================================

Name: mips_trace_buffer

Overview:
- Synthesizable execution-trace capture block for the single-cycle MIPS core.
- Records retired-instruction events (PC, instruction, register/memory write and branch info) into a circular buffer of parametrised depth.
- Supports selectable trigger modes with post-trigger capture, and a valid/ready readout port.
- Sits beside mipsProcessor and taps its PC, instruction, RegWrite, MemWrite and branch_taken signals.

Parameters:
- DEPTH, 16, number of trace entries; power of two, >= 4.
- PC_W, 32, PC and trig_pc width.
- DATA_W, 32, instruction and write-data width.
- RA_W, 5, register address width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- arm  in  1  pulse: clear buffer, start capture.
- stop  in  1  pulse: force end of capture.
- trig_mode  in  2  0=free-run (no trigger), 1=PC match, 2=branch taken, 3=memory write.
- trig_pc  in  PC_W  PC compared in mode 1.
- post_count  in  $clog2(DEPTH)  entries to capture after the trigger entry.
- cap_valid  in  1  a retired instruction is presented this cycle.
- cap_pc  in  PC_W  PC of the retired instruction.
- cap_instr  in  DATA_W  instruction word.
- cap_regwrite  in  1  RegWrite.
- cap_wreg  in  RA_W  destination register.
- cap_wdata  in  DATA_W  write-back value.
- cap_memwrite  in  1  MemWrite.
- cap_branch  in  1  branch taken.
- rd_valid  out  1  head entry available.
- rd_ready  in  1  consumer accepts the head entry.
- rd_pc, rd_instr, rd_wdata  out  PC_W/DATA_W/DATA_W  head entry fields.
- rd_wreg  out  RA_W  head entry field.
- rd_flags  out  3  {regwrite, memwrite, branch} of the head entry.
- state  out  3  current FSM state.
- count  out  $clog2(DEPTH)+1  valid entries held.
- triggered  out  1  trigger fired in this capture.
- overflow  out  1  more than DEPTH entries captured since arm.

Behaviour:
- Reset values: FSM IDLE; wr_ptr, rd_ptr, count, remaining = 0; triggered = 0; overflow = 0; rd_valid = 0. All rd_* fields read 0 while rd_valid = 0. Entry RAM contents are not reset.
- States: IDLE=0, ARMED=1, POST=2, DONE=3.
- IDLE:
  - arm -> ARMED; clear pointers, count, triggered and overflow.
  - stop is ignored.
- ARMED:
  - Each cap_valid writes one entry at wr_ptr; wr_ptr increments mod DEPTH.
  - count saturates at DEPTH. A write while count==DEPTH sets overflow (sticky) and overwrites the oldest entry.
  - Trigger is evaluated on the entry being written:
    - mode 1: cap_pc==trig_pc.
    - mode 2: cap_branch.
    - mode 3: cap_memwrite.
    - mode 0: never fires.
  - On trigger: set triggered. If post_count==0 -> DONE; else -> POST with remaining=post_count.
- POST:
  - Each cap_valid writes one entry and decrements remaining.
  - The write that brings remaining to 0 -> DONE.
  - Because post_count <= DEPTH-1, the trigger entry is always retained.
- DONE:
  - Capture is ignored.
  - rd_valid = (count != 0). The head entry is the oldest: rd_ptr is set to (wr_ptr - count) mod DEPTH on entry to DONE.
  - rd_valid && rd_ready: pop, rd_ptr++, count--.
  - When the final pop makes count 0 -> IDLE in the same edge.
  - Entering DONE with count==0 (stop before any capture) -> IDLE on the next cycle.
- Readout: combinational from RAM at rd_ptr, zero latency. Fields stay stable while rd_valid && !rd_ready.
- stop in ARMED or POST -> DONE. If cap_valid is high in the same cycle, that entry is written first, then stop is applied.
- arm and stop in the same cycle: arm wins.
- arm in ARMED, POST or DONE: restart as from IDLE; unread data is discarded.
- Trigger and stop in the same cycle: DONE, with triggered=1.
- Reset asserted mid-operation: immediate return to reset values, including mid-readout.

Decomposition:
- Shared include file mips_trace_defs.vh holds:
  - state encodings ST_IDLE..ST_DONE;
  - trigger-mode constants TRIG_FREE, TRIG_PC, TRIG_BRANCH, TRIG_MEMW;
  - ENTRY_W = 2*DATA_W + PC_W + RA_W + 3 and the entry field offsets.
- Sub-module trace_ram: DEPTH x ENTRY_W, synchronous write, asynchronous read, no reset.
- mips_trace_buffer contains the FSM, pointers and trigger logic.

Test Plan (DEPTH=8):
- Reset, no stimulus -> state=0, count=0, rd_valid=0, triggered=0, overflow=0.
- Mode 0, arm, 5 captures with pc=0x00..0x10 step 4, then stop -> count=5, overflow=0. Pops return pc 0x00,0x04,0x08,0x0C,0x10 in order; state=IDLE after the last pop.
- Mode 0, 12 captures with pc=0x00..0x2C, then stop -> count=8, overflow=1. Pops return pc 0x10..0x2C.
- Mode 1, trig_pc=0x20, post_count=2, captures with pc=0x00..0x40 -> DONE after pc 0x28 is captured; triggered=1. Buffer holds pc 0x0C..0x28; later captures are ignored.
- Mode 2, post_count=0, branch on the 3rd capture (pc=0x08) -> DONE, count=3. rd_ready held low for 3 cycles -> rd_pc=0x00 stable throughout.
- arm and stop in the same cycle -> state=ARMED. Later, assert reset during readout with count=4 -> count=0, state=IDLE, rd_valid=0 immediately.

Source files
------------

// File: rtl/mips_trace_buffer_pkg.sv
// Shared definitions for the MIPS execution-trace buffer: FSM states, trigger modes
// and the packed entry layout.
package mips_trace_buffer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_POST  = 3'd2,
        ST_DONE  = 3'd3
    } state_t;

    localparam logic [1:0] TRIG_FREE   = 2'd0;
    localparam logic [1:0] TRIG_PC     = 2'd1;
    localparam logic [1:0] TRIG_BRANCH = 2'd2;
    localparam logic [1:0] TRIG_MEMW   = 2'd3;

    localparam int unsigned FLAGS_W = 3;

    // Entry layout, LSB first: pc, instr, wdata, wreg, flags.
    function automatic int unsigned entry_w(int unsigned pc_w, int unsigned data_w,
                                            int unsigned ra_w);
        return 2 * data_w + pc_w + ra_w + FLAGS_W;
    endfunction

endpackage

// File: rtl/mips_trace_buffer_trace_ram.sv
// Trace entry storage: synchronous write, asynchronous read, contents not reset.
module trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 104
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mips_trace_buffer.sv
// Execution-trace capture for the single-cycle MIPS core: circular buffer with
// trigger, post-trigger capture and valid/ready readout of the oldest entry.
module mips_trace_buffer
    import mips_trace_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RA_W   = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       arm,
    input  logic                       stop,
    input  logic [1:0]                 trig_mode,
    input  logic [PC_W-1:0]            trig_pc,
    input  logic [$clog2(DEPTH)-1:0]   post_count,
    input  logic                       cap_valid,
    input  logic [PC_W-1:0]            cap_pc,
    input  logic [DATA_W-1:0]          cap_instr,
    input  logic                       cap_regwrite,
    input  logic [RA_W-1:0]            cap_wreg,
    input  logic [DATA_W-1:0]          cap_wdata,
    input  logic                       cap_memwrite,
    input  logic                       cap_branch,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [PC_W-1:0]            rd_pc,
    output logic [DATA_W-1:0]          rd_instr,
    output logic [DATA_W-1:0]          rd_wdata,
    output logic [RA_W-1:0]            rd_wreg,
    output logic [2:0]                 rd_flags,
    output logic [2:0]                 state,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       triggered,
    output logic                       overflow
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned CW        = AW + 1;
    localparam int unsigned ENTRY_W   = entry_w(PC_W, DATA_W, RA_W);
    localparam int unsigned OFF_PC    = 0;
    localparam int unsigned OFF_INSTR = OFF_PC + PC_W;
    localparam int unsigned OFF_WDATA = OFF_INSTR + DATA_W;
    localparam int unsigned OFF_WREG  = OFF_WDATA + DATA_W;
    localparam int unsigned OFF_FLAGS = OFF_WREG + RA_W;

    state_t          state_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q, remaining_q;
    logic [CW-1:0]   count_q;
    logic            triggered_q, overflow_q;

    logic            capturing, wr_en, trig_hit, full, enter_done, pop;
    logic [AW-1:0]   wr_ptr_after, rd_ptr_done;
    logic [CW-1:0]   count_after;
    logic [ENTRY_W-1:0] wr_entry, rd_entry;

    // arm takes priority over a simultaneous capture: the buffer is being cleared.
    assign capturing = (state_q == ST_ARMED) || (state_q == ST_POST);
    assign wr_en     = capturing && cap_valid && !arm;
    assign full      = (count_q == CW'(DEPTH));

    always_comb begin
        trig_hit = 1'b0;
        case (trig_mode)
            TRIG_PC:     trig_hit = (cap_pc == trig_pc);
            TRIG_BRANCH: trig_hit = cap_branch;
            TRIG_MEMW:   trig_hit = cap_memwrite;
            default:     trig_hit = 1'b0;
        endcase
    end

    always_comb begin
        wr_ptr_after = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_after  = (wr_en && !full) ? count_q + 1'b1 : count_q;
        // When full, count_after[AW-1:0] is 0 and the oldest entry sits at wr_ptr.
        rd_ptr_done  = wr_ptr_after - count_after[AW-1:0];
        enter_done   = 1'b0;
        if (state_q == ST_ARMED) begin
            enter_done = stop || (wr_en && trig_hit && (post_count == '0));
        end else if (state_q == ST_POST) begin
            enter_done = stop || (wr_en && (remaining_q == AW'(1)));
        end
    end

    assign rd_valid = (state_q == ST_DONE) && (count_q != '0);
    assign pop      = rd_valid && rd_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            count_q     <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (arm) begin
            state_q     <= ST_ARMED;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            count_q     <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_ARMED, ST_POST: begin
                    wr_ptr_q <= wr_ptr_after;
                    count_q  <= count_after;
                    if (wr_en && full) begin
                        overflow_q <= 1'b1;
                    end
                    if (state_q == ST_ARMED && wr_en && trig_hit) begin
                        triggered_q <= 1'b1;
                        remaining_q <= post_count;
                        if (!enter_done) begin
                            state_q <= ST_POST;
                        end
                    end
                    if (state_q == ST_POST && wr_en) begin
                        remaining_q <= remaining_q - 1'b1;
                    end
                    if (enter_done) begin
                        state_q  <= ST_DONE;
                        rd_ptr_q <= rd_ptr_done;
                    end
                end
                ST_DONE: begin
                    if (count_q == '0) begin
                        state_q <= ST_IDLE;
                    end else if (pop) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        count_q  <= count_q - 1'b1;
                        if (count_q == CW'(1)) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_entry = {cap_regwrite, cap_memwrite, cap_branch, cap_wreg, cap_wdata, cap_instr,
                       cap_pc};

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    assign rd_pc     = rd_valid ? rd_entry[OFF_PC +: PC_W]        : '0;
    assign rd_instr  = rd_valid ? rd_entry[OFF_INSTR +: DATA_W]   : '0;
    assign rd_wdata  = rd_valid ? rd_entry[OFF_WDATA +: DATA_W]   : '0;
    assign rd_wreg   = rd_valid ? rd_entry[OFF_WREG +: RA_W]      : '0;
    assign rd_flags  = rd_valid ? rd_entry[OFF_FLAGS +: FLAGS_W]  : '0;

    assign state     = state_q;
    assign count     = count_q;
    assign triggered = triggered_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed self-checking bench for mips_trace_buffer with DEPTH=8.
module tb_mips_trace_buffer;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm, stop, cap_valid, cap_regwrite, cap_memwrite, cap_branch, rd_ready;
    logic [1:0]  trig_mode;
    logic [31:0] trig_pc, cap_pc, cap_instr, cap_wdata;
    logic [2:0]  post_count;
    logic [4:0]  cap_wreg;
    logic        rd_valid, triggered, overflow;
    logic [31:0] rd_pc, rd_instr, rd_wdata;
    logic [4:0]  rd_wreg;
    logic [2:0]  rd_flags, state;
    logic [3:0]  count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_trace_buffer #(
        .DEPTH  (DEPTH),
        .PC_W   (32),
        .DATA_W (32),
        .RA_W   (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .arm          (arm),
        .stop         (stop),
        .trig_mode    (trig_mode),
        .trig_pc      (trig_pc),
        .post_count   (post_count),
        .cap_valid    (cap_valid),
        .cap_pc       (cap_pc),
        .cap_instr    (cap_instr),
        .cap_regwrite (cap_regwrite),
        .cap_wreg     (cap_wreg),
        .cap_wdata    (cap_wdata),
        .cap_memwrite (cap_memwrite),
        .cap_branch   (cap_branch),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_pc        (rd_pc),
        .rd_instr     (rd_instr),
        .rd_wdata     (rd_wdata),
        .rd_wreg      (rd_wreg),
        .rd_flags     (rd_flags),
        .state        (state),
        .count        (count),
        .triggered    (triggered),
        .overflow     (overflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm(input logic [1:0] mode, input logic [31:0] tpc,
                             input logic [2:0] post);
        trig_mode  = mode;
        trig_pc    = tpc;
        post_count = post;
        arm        = 1'b1;
        tick();
        arm        = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // Instruction/wdata/wreg are derived from pc so pops can be checked field by field.
    task automatic capture(input logic [31:0] pc, input logic br, input logic mw,
                           input logic stp);
        cap_valid    = 1'b1;
        cap_pc       = pc;
        cap_instr    = 32'h2400_0000 | pc;
        cap_regwrite = ~mw;
        cap_wreg     = pc[6:2];
        cap_wdata    = ~pc;
        cap_memwrite = mw;
        cap_branch   = br;
        stop         = stp;
        tick();
        cap_valid    = 1'b0;
        cap_branch   = 1'b0;
        cap_memwrite = 1'b0;
        stop         = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [31:0] exp_pc, input logic [2:0] exp_flags);
        logic [31:0] exp_wdata;
        logic [4:0]  exp_wreg;
        exp_wdata = ~exp_pc;
        exp_wreg  = exp_pc[6:2];
        check({tag, "_valid"}, rd_valid, 1'b1);
        check({tag, "_pc"}, rd_pc, exp_pc);
        check({tag, "_instr"}, rd_instr, 32'h2400_0000 | exp_pc);
        check({tag, "_wdata"}, rd_wdata, exp_wdata);
        check({tag, "_wreg"}, rd_wreg, exp_wreg);
        check({tag, "_flags"}, rd_flags, exp_flags);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; arm = 1'b0; stop = 1'b0; cap_valid = 1'b0; rd_ready = 1'b0;
        cap_regwrite = 1'b0; cap_memwrite = 1'b0; cap_branch = 1'b0;
        trig_mode = 2'd0; trig_pc = '0; post_count = '0;
        cap_pc = '0; cap_instr = '0; cap_wdata = '0; cap_wreg = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        check("rst_state", state, 3'd0);
        check("rst_count", count, 4'd0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_triggered", triggered, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_rd_pc", rd_pc, 32'h0);

        pulse_stop();
        check("idle_stop_ignored", state, 3'd0);

        // Free-run, 5 captures then stop.
        pulse_arm(2'd0, 32'h0, 3'd0);
        check("m0_armed", state, 3'd1);
        for (int i = 0; i < 5; i++) capture(32'(i * 4), 1'b0, 1'b0, 1'b0);
        pulse_stop();
        check("m0_done", state, 3'd3);
        check("m0_count", count, 4'd5);
        check("m0_overflow", overflow, 1'b0);
        for (int i = 0; i < 5; i++) pop($sformatf("m0_pop%0d", i), 32'(i * 4), 3'b100);
        check("m0_idle", state, 3'd0);
        check("m0_empty", rd_valid, 1'b0);

        // Free-run overflow: 12 captures into 8 entries.
        pulse_arm(2'd0, 32'h0, 3'd0);
        for (int i = 0; i < 12; i++) capture(32'(i * 4), 1'b0, 1'b0, 1'b0);
        pulse_stop();
        check("ovf_count", count, 4'd8);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_trig", triggered, 1'b0);
        for (int i = 0; i < 8; i++) pop($sformatf("ovf_pop%0d", i), 32'h10 + 32'(i * 4), 3'b100);
        check("ovf_idle", state, 3'd0);

        // PC trigger at 0x20 with two post-trigger entries.
        pulse_arm(2'd1, 32'h20, 3'd2);
        for (int i = 0; i <= 16; i++) begin
            capture(32'(i * 4), 1'b0, 1'b0, 1'b0);
            if (i == 8) check("pc_post_after_trig", state, 3'd2);
            if (i == 9) check("pc_post_mid", state, 3'd2);
            if (i == 10) check("pc_done_after_28", state, 3'd3);
        end
        check("pc_state", state, 3'd3);
        check("pc_triggered", triggered, 1'b1);
        check("pc_count", count, 4'd8);
        for (int i = 0; i < 8; i++) pop($sformatf("pc_pop%0d", i), 32'h0C + 32'(i * 4), 3'b100);
        check("pc_idle", state, 3'd0);

        // Branch trigger, no post entries; head stays stable while not accepted.
        pulse_arm(2'd2, 32'h0, 3'd0);
        capture(32'h00, 1'b0, 1'b0, 1'b0);
        capture(32'h04, 1'b0, 1'b0, 1'b0);
        capture(32'h08, 1'b1, 1'b0, 1'b0);
        check("br_state", state, 3'd3);
        check("br_count", count, 4'd3);
        check("br_triggered", triggered, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("br_hold%0d", i), rd_pc, 32'h00);
            tick();
        end
        capture(32'h0C, 1'b1, 1'b0, 1'b0);
        check("br_ignored_capture", count, 4'd3);
        pop("br_pop0", 32'h00, 3'b100);
        pop("br_pop1", 32'h04, 3'b100);
        pop("br_pop2", 32'h08, 3'b101);
        check("br_idle", state, 3'd0);

        // Memory-write trigger with one post entry.
        pulse_arm(2'd3, 32'h0, 3'd1);
        capture(32'h40, 1'b0, 1'b0, 1'b0);
        capture(32'h44, 1'b0, 1'b1, 1'b0);
        check("mw_post", state, 3'd2);
        capture(32'h48, 1'b0, 1'b0, 1'b0);
        check("mw_state", state, 3'd3);
        check("mw_count", count, 4'd3);
        pop("mw_pop0", 32'h40, 3'b100);
        pop("mw_pop1", 32'h44, 3'b010);

        // Arm during readout discards data; stop with arm in the same cycle loses.
        arm = 1'b1; stop = 1'b1;
        tick();
        arm = 1'b0; stop = 1'b0;
        check("armstop_state", state, 3'd1);
        check("armstop_count", count, 4'd0);

        // Stop together with a capture keeps that entry; then reset during readout.
        pulse_arm(2'd0, 32'h0, 3'd0);
        capture(32'h100, 1'b0, 1'b0, 1'b0);
        capture(32'h104, 1'b0, 1'b0, 1'b0);
        capture(32'h108, 1'b0, 1'b0, 1'b0);
        capture(32'h10C, 1'b0, 1'b0, 1'b1);
        check("stopcap_state", state, 3'd3);
        check("stopcap_count", count, 4'd4);
        check("stopcap_head", rd_pc, 32'h100);
        rd_ready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("rstmid_count", count, 4'd0);
        check("rstmid_state", state, 3'd0);
        check("rstmid_rd_valid", rd_valid, 1'b0);
        check("rstmid_rd_pc", rd_pc, 32'h0);
        rd_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_state", state, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
